// File: rtl/sram_axi_pkg.sv
// Shared types and AXI constants for the SRAM-to-AXI bridge.
package sram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } state_t;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;

endpackage

// File: rtl/sram_axi_port_ctx.sv
// Per-port context: done flag, held read data and the port's stall contribution.
module sram_axi_port_ctx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              complete,
  input  logic              load,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              advance,
  output logic              stall,
  output logic [DATA_W-1:0] rdata
);

  logic done_q;

  // Done is set when this port's access finishes and cleared when the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (complete) begin
      done_q <= 1'b1;
    end else if (advance) begin
      done_q <= 1'b0;
    end
  end

  // Read data is captured only on this port's R handshake and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (load) begin
      rdata <= rdata_in;
    end
  end

  assign stall = en & ~done_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM ports onto one AXI3 master
// with a single outstanding transaction. Optional macro
// SRAM_AXI_POSTED_WRITE_EN releases the store stall before the B response.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no bus access; arbitrate pending ports (data first)
// ST_AR   | read address valid, waiting for arready
// ST_R    | rready high, waiting for the read beat
// ST_W    | awvalid/wvalid raised, each drops after its own handshake
// ST_B    | bready high, waiting for the write response
module sram_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_sram_en,
  input  logic [3:0]          inst_sram_wen,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_en,
  input  logic [3:0]          data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq_for_bus,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t              state_q, state_d;
  logic [3:0]          arid_q;
  logic [ADDR_W-1:0]   araddr_q, awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid_q, wvalid_q;
  logic                ar_load, ar_sel_data, w_load;
  logic                inst_complete, inst_load, data_complete, data_load;
  logic                inst_stall, data_stall, advance;
  logic                b_pending_q;
  logic                aw_done_now, w_done_now;

  // Responses are matched by FSM state, so the returned ids and status are not consulted.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, rid, rresp, rlast, bid, bresp};

  assign stallreq_for_bus = ~rst & (inst_stall | data_stall);
  assign advance          = ~stallreq_for_bus;
  assign aw_done_now      = ~awvalid_q | awready;
  assign w_done_now       = ~wvalid_q | wready;

  sram_axi_port_ctx #(.DATA_W(DATA_W)) u_inst_ctx (
    .clk(clk), .rst(rst), .en(inst_sram_en), .complete(inst_complete), .load(inst_load),
    .rdata_in(rdata), .advance(advance), .stall(inst_stall), .rdata(inst_sram_rdata)
  );

  sram_axi_port_ctx #(.DATA_W(DATA_W)) u_data_ctx (
    .clk(clk), .rst(rst), .en(data_sram_en), .complete(data_complete), .load(data_load),
    .rdata_in(rdata), .advance(advance), .stall(data_stall), .rdata(data_sram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle strobes; data port wins arbitration in IDLE.
  always_comb begin
    state_d       = state_q;
    ar_load       = 1'b0;
    ar_sel_data   = 1'b0;
    w_load        = 1'b0;
    inst_complete = 1'b0;
    inst_load     = 1'b0;
    data_complete = 1'b0;
    data_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!b_pending_q) begin
          if (data_stall) begin
            if (data_sram_wen != 4'b0000) begin
              state_d = ST_W;
              w_load  = 1'b1;
            end else begin
              state_d     = ST_AR;
              ar_load     = 1'b1;
              ar_sel_data = 1'b1;
            end
          end else if (inst_stall) begin
            state_d = ST_AR;
            ar_load = 1'b1;
          end
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          state_d = ST_IDLE;
          if (arid_q == ID_DATA) begin
            data_complete = 1'b1;
            data_load     = 1'b1;
          end else begin
            inst_complete = 1'b1;
            inst_load     = 1'b1;
          end
        end
      end
      ST_W: begin
        if (aw_done_now && w_done_now) begin
`ifdef SRAM_AXI_POSTED_WRITE_EN
          state_d       = ST_IDLE;
          data_complete = 1'b1;
`else
          state_d = ST_B;
`endif
        end
      end
      ST_B: begin
        if (bvalid) begin
          state_d       = ST_IDLE;
          data_complete = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AXI address/data registers, loaded once when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      arid_q    <= ID_INST;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      if (ar_load) begin
        arid_q   <= ar_sel_data ? ID_DATA : ID_INST;
        araddr_q <= ar_sel_data ? data_sram_addr : inst_sram_addr;
      end
      if (w_load) begin
        awaddr_q  <= {data_sram_addr[ADDR_W-1:2], 2'b00};
        wdata_q   <= data_sram_wdata;
        wstrb_q   <= data_sram_wen;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end else begin
        if (awready) awvalid_q <= 1'b0;
        if (wready)  wvalid_q  <= 1'b0;
      end
    end
  end

`ifdef SRAM_AXI_POSTED_WRITE_EN
  // Outstanding write response after a posted store; blocks new transactions until B arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_pending_q <= 1'b0;
    end else if (state_q == ST_W && aw_done_now && w_done_now) begin
      b_pending_q <= 1'b1;
    end else if (bvalid) begin
      b_pending_q <= 1'b0;
    end
  end
`else
  assign b_pending_q = 1'b0;
`endif

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);
  assign awid    = ID_DATA;
  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wid     = ID_DATA;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = (state_q == ST_B) | b_pending_q;

  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: vector table of single accesses plus
// hand-written multi-cycle sequences, against a delay-configurable AXI slave.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0, inst_sram_wdata = 32'h0, inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0, data_sram_wdata = 32'h0, data_sram_rdata;
  logic        stallreq_for_bus;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = 4'h0, bid = 4'h0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        rlast = 1'b1;
  logic [31:0] rdata = 32'h0;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .stallreq_for_bus(stallreq_for_bus),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

`ifdef SRAM_AXI_POSTED_WRITE_EN
  localparam int WR_STALL = 2;
  localparam int WR_DLY_STALL = 4;
`else
  localparam int WR_STALL = 3;
  localparam int WR_DLY_STALL = 5;
`endif

  int n_err = 0, n_checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model and monitors (all at negedge) ----------------
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] rd_inst_val = 32'h0, rd_data_val = 32'h0;
  logic        r_owed = 0, aw_got = 0, w_got = 0, b_owed = 0;
  logic [3:0]  r_id = 4'h0;
  logic        p_rst = 1, p_ar_hs = 0, p_r_hs = 0, p_aw_hs = 0, p_w_hs = 0, p_b_hs = 0;
  logic        p_ar_stall = 0, p_aw_stall = 0, p_w_stall = 0;
  logic [3:0]  p_arid = 4'h0;
  logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0, p_inst_rd = 0, p_data_rd = 0;
  logic [3:0]  ar_ids[$];
  logic [31:0] ar_addrs[$];
  int          aw_n = 0, stab_err = 0, glitch_err = 0;
  int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0, b_hs_cyc = -1, ar_first_cyc = -1;
  logic [31:0] last_awaddr = 0, last_wdata = 0;
  logic [3:0]  last_awid = 0, last_wstrb = 0;
  logic        last_wlast = 0;

  always @(negedge clk) begin
    if (p_rst) begin
      r_owed = 0; aw_got = 0; w_got = 0; b_owed = 0;
    end else begin
      if (p_r_hs) r_owed = 0;
      if (p_ar_hs) begin r_owed = 1; r_id = p_arid; end
      if (p_aw_hs) aw_got = 1;
      if (p_w_hs) w_got = 1;
      if (aw_got && w_got) begin b_owed = 1; aw_got = 0; w_got = 0; end
      if (p_b_hs) b_owed = 0;
      if (p_ar_stall && (!arvalid || araddr !== p_araddr || arid !== p_arid)) stab_err++;
      if (p_aw_stall && (!awvalid || awaddr !== p_awaddr)) stab_err++;
      if (p_w_stall && (!wvalid || wdata !== p_wdata)) stab_err++;
      if ((inst_sram_rdata !== p_inst_rd || data_sram_rdata !== p_data_rd) && !p_r_hs) glitch_err++;
    end
    if (arvalid) begin arready = (ar_wait >= ar_delay); ar_wait++; end else begin arready = 0; ar_wait = 0; end
    if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end else begin awready = 0; aw_wait = 0; end
    if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end else begin wready = 0; w_wait = 0; end
    if (r_owed) begin rvalid = (r_wait >= r_delay); r_wait++; end else begin rvalid = 0; r_wait = 0; end
    if (b_owed) begin bvalid = (b_wait >= b_delay); b_wait++; end else begin bvalid = 0; b_wait = 0; end
    rdata = (r_id == 4'd1) ? rd_data_val : rd_inst_val;
    rid = r_id;
    if (arvalid) begin ar_cyc++; if (ar_first_cyc < 0) ar_first_cyc = cyc; end
    if (awvalid) aw_cyc++;
    if (wvalid) w_cyc++;
    if (!rst && arvalid && arready) begin ar_ids.push_back(arid); ar_addrs.push_back(araddr); end
    if (!rst && awvalid && awready) begin aw_n++; last_awaddr = awaddr; last_awid = awid; end
    if (!rst && wvalid && wready) begin last_wdata = wdata; last_wstrb = wstrb; last_wlast = wlast; end
    if (!rst && bvalid && bready) b_hs_cyc = cyc;
    p_rst = rst;
    p_ar_hs = arvalid && arready; p_r_hs = rvalid && rready;
    p_aw_hs = awvalid && awready; p_w_hs = wvalid && wready; p_b_hs = bvalid && bready;
    p_ar_stall = arvalid && !arready; p_aw_stall = awvalid && !awready; p_w_stall = wvalid && !wready;
    p_arid = arid; p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata;
    p_inst_rd = inst_sram_rdata; p_data_rd = data_sram_rdata;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; presents a request, counts stall cycles, drops en after the advance edge.
  task automatic run_req(input logic ie, input logic [3:0] iwen, input logic [31:0] ia,
                         input logic de, input logic [3:0] dwen, input logic [31:0] da,
                         input logic [31:0] dwd, output int n);
    inst_sram_en = ie; inst_sram_wen = iwen; inst_sram_addr = ia;
    data_sram_en = de; data_sram_wen = dwen; data_sram_addr = da; data_sram_wdata = dwd;
    #1;
    n = 0;
    while (stallreq_for_bus && n < 60) begin n++; @(posedge clk); #2; end
    @(posedge clk); #1;
    inst_sram_en = 0; data_sram_en = 0; inst_sram_wen = 0; data_sram_wen = 0;
  endtask

  task automatic idle_tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_data;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] resp;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    int          exp_stall;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int n, n0, a0;
    logic [31:0] exp_inst, exp_data;

    vecs[0] = '{1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h3C1D0000, 4'd0, 32'hBFC00000, 4'h0, 3};
    vecs[1] = '{1'b1, 4'h0, 32'h80001000, 32'h0,        32'hDEADBEEF, 4'd1, 32'h80001000, 4'h0, 3};
    vecs[2] = '{1'b1, 4'h4, 32'h80000002, 32'h00AB0000, 32'h0,        4'd1, 32'h80000000, 4'h4, WR_STALL};
    vecs[3] = '{1'b1, 4'hF, 32'h80000010, 32'h12345678, 32'h0,        4'd1, 32'h80000010, 4'hF, WR_STALL};
    vecs[4] = '{1'b0, 4'hF, 32'hBFC00008, 32'h0,        32'h24080001, 4'd0, 32'hBFC00008, 4'h0, 3};
    vecs[5] = '{1'b1, 4'h0, 32'h80000FFC, 32'h0,        32'h000000FF, 4'd1, 32'h80000FFC, 4'h0, 3};
    vecs[6] = '{1'b1, 4'h3, 32'h80000021, 32'h0000BEEF, 32'h0,        4'd1, 32'h80000020, 4'h3, WR_STALL};

    // Reset: stall forced low even with a pending fetch.
    inst_sram_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_forced_by_rst", {31'b0, stallreq_for_bus}, 32'd0);
    rst = 0; inst_sram_en = 0;
    #1;
    chk("rst_arvalid", {31'b0, arvalid}, 0);
    chk("rst_valids_readies", {27'b0, awvalid, wvalid, rready, bready, stallreq_for_bus}, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);
    chk("const_ar_fields", {20'b0, arlen, arsize, arburst, arlock, arprot}, {20'b0, 4'd0, 3'd2, 2'b01, 2'b00, 3'd0});
    chk("const_aw_fields", {20'b0, awlen, awsize, awburst, awlock, awprot}, {20'b0, 4'd0, 3'd2, 2'b01, 2'b00, 3'd0});
    exp_inst = 0; exp_data = 0;
    idle_tick();

    // Vector table: single zero-wait accesses.
    for (int i = 0; i < 7; i++) begin
      rd_inst_val = vecs[i].resp; rd_data_val = vecs[i].resp;
      n0 = ar_ids.size(); a0 = aw_n;
      if (vecs[i].is_data)
        run_req(0, 4'h0, 32'h0, 1, vecs[i].wen, vecs[i].addr, vecs[i].wdat, n);
      else
        run_req(1, vecs[i].wen, vecs[i].addr, 0, 4'h0, 32'h0, 32'h0, n);
      chk($sformatf("v%0d_stall_cycles", i), n, vecs[i].exp_stall);
      if (vecs[i].is_data && vecs[i].wen != 4'h0) begin
        chk($sformatf("v%0d_aw_count", i), aw_n, a0 + 1);
        chk($sformatf("v%0d_no_ar", i), ar_ids.size(), n0);
        chk($sformatf("v%0d_awaddr", i), last_awaddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_awid", i), last_awid, vecs[i].exp_id);
        chk($sformatf("v%0d_wstrb", i), last_wstrb, vecs[i].exp_strb);
        chk($sformatf("v%0d_wdata_wlast", i), {last_wdata[30:0], last_wlast}, {vecs[i].wdat[30:0], 1'b1});
      end else begin
        chk($sformatf("v%0d_ar_count", i), ar_ids.size(), n0 + 1);
        chk($sformatf("v%0d_arid", i), ar_ids[ar_ids.size()-1], vecs[i].exp_id);
        chk($sformatf("v%0d_araddr", i), ar_addrs[ar_addrs.size()-1], vecs[i].exp_addr);
        if (vecs[i].is_data) exp_data = vecs[i].resp; else exp_inst = vecs[i].resp;
      end
      chk($sformatf("v%0d_inst_rdata", i), inst_sram_rdata, exp_inst);
      chk($sformatf("v%0d_data_rdata", i), data_sram_rdata, exp_data);
      idle_tick();
    end

    // Simultaneous fetch and load: data first, stall held for both.
    rd_inst_val = 32'h8FBF0010; rd_data_val = 32'h00000042;
    n0 = ar_ids.size();
    run_req(1, 4'h0, 32'hBFC00004, 1, 4'h0, 32'h80001000, 32'h0, n);
    chk("dual_stall_cycles", n, 6);
    chk("dual_ar_count", ar_ids.size(), n0 + 2);
    chk("dual_first_arid", ar_ids[n0], 4'd1);
    chk("dual_first_araddr", ar_addrs[n0], 32'h80001000);
    chk("dual_second_arid", ar_ids[n0+1], 4'd0);
    chk("dual_second_araddr", ar_addrs[n0+1], 32'hBFC00004);
    chk("dual_inst_rdata", inst_sram_rdata, 32'h8FBF0010);
    chk("dual_data_rdata", data_sram_rdata, 32'h00000042);
    exp_inst = 32'h8FBF0010; exp_data = 32'h00000042;
    idle_tick();

    // sb with awready delayed 2 cycles: aw held, w drops independently.
    aw_delay = 2; aw_cyc = 0; w_cyc = 0;
    run_req(0, 4'h0, 32'h0, 1, 4'b0100, 32'h80000002, 32'h00AB0000, n);
    aw_delay = 0;
    chk("sb_stall_cycles", n, WR_DLY_STALL);
    chk("sb_awaddr", last_awaddr, 32'h80000000);
    chk("sb_wstrb", last_wstrb, 4'b0100);
    chk("sb_wlast", {31'b0, last_wlast}, 1);
    chk("sb_wdata", last_wdata, 32'h00AB0000);
    chk("sb_awvalid_cycles", aw_cyc, 3);
    chk("sb_wvalid_cycles", w_cyc, 1);
    chk("sb_stability", stab_err, 0);
    idle_tick();

    // Read backpressure: arready after 5 low cycles, rvalid 4 cycles late.
    ar_delay = 5; r_delay = 4; ar_cyc = 0;
    rd_data_val = 32'hCAFEF00D;
    run_req(0, 4'h0, 32'h0, 1, 4'h0, 32'h80002000, 32'h0, n);
    ar_delay = 0; r_delay = 0;
    chk("bp_stall_cycles", n, 12);
    chk("bp_arvalid_cycles", ar_cyc, 6);
    chk("bp_araddr", ar_addrs[ar_addrs.size()-1], 32'h80002000);
    chk("bp_data_rdata", data_sram_rdata, 32'hCAFEF00D);
    chk("bp_inst_rdata_held", inst_sram_rdata, exp_inst);
    chk("bp_stability", stab_err, 0);
    chk("rdata_only_on_r_handshake", glitch_err, 0);
    idle_tick();

    // Reset pulsed while in R.
    r_delay = 20; rd_inst_val = 32'h11111111;
    inst_sram_en = 1; inst_sram_wen = 0; inst_sram_addr = 32'hBFC00010;
    #1;
    n = 0;
    while (!rready && n < 40) begin n++; @(posedge clk); #2; end
    chk("rst_test_reached_r", {31'b0, rready}, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rst_in_r_stall_forced", {31'b0, stallreq_for_bus}, 0);
    @(posedge clk); #1;
    rst = 0; inst_sram_en = 0; r_delay = 0;
    #1;
    chk("rst_in_r_valids", {27'b0, arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_in_r_stall", {31'b0, stallreq_for_bus}, 0);
    chk("rst_in_r_inst_rdata", inst_sram_rdata, 0);
    chk("rst_in_r_data_rdata", data_sram_rdata, 0);
    idle_tick();
    rd_inst_val = 32'h27BDFFE8;
    run_req(1, 4'h0, 32'hBFC00014, 0, 4'h0, 32'h0, 32'h0, n);
    chk("post_rst_fetch_stall", n, 3);
    chk("post_rst_fetch_rdata", inst_sram_rdata, 32'h27BDFFE8);
    idle_tick();

`ifdef SRAM_AXI_POSTED_WRITE_EN
    // Posted store then load with bvalid delayed 3 cycles.
    b_delay = 3; b_hs_cyc = -1;
    data_sram_en = 1; data_sram_wen = 4'hF; data_sram_addr = 32'h80000040; data_sram_wdata = 32'h11223344;
    #1;
    n = 0;
    while (stallreq_for_bus && n < 60) begin n++; @(posedge clk); #2; end
    chk("posted_store_stall", n, 2);
    @(posedge clk); #1;
    ar_first_cyc = -1; rd_data_val = 32'h55667788;
    data_sram_wen = 4'h0; data_sram_addr = 32'h80000044;
    #1;
    n = 0;
    while (stallreq_for_bus && n < 60) begin n++; @(posedge clk); #2; end
    @(posedge clk); #1;
    data_sram_en = 0; b_delay = 0;
    chk("posted_b_seen", {31'b0, b_hs_cyc >= 0}, 1);
    chk("posted_ar_after_b", {31'b0, ar_first_cyc > b_hs_cyc}, 1);
    chk("posted_load_rdata", data_sram_rdata, 32'h55667788);
    idle_tick();
`endif

    chk("final_stability", stab_err, 0);
    chk("final_rdata_glitch", glitch_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like ports (instruction and data) into a single AXI3 master with one outstanding transaction, and returns a stall request that freezes the pipeline while a bus access is in flight. It sits directly downstream of the CPU core, between its inst/data SRAM ports and the SoC interconnect.

## Interface
- ADDR_W, 32, address width for core and AXI
- DATA_W, 32, data width; only 32 is supported
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_sram_en  in  1  instruction request; held stable by the core while stalled
- inst_sram_wen  in  4  must be 0; nonzero is ignored and treated as a read
- inst_sram_addr  in  32  instruction byte address
- inst_sram_wdata  in  32  unused
- inst_sram_rdata  out  32  fetched word; held until the next completed instruction read
- data_sram_en  in  1  data request; held stable while stalled
- data_sram_wen  in  4  byte strobes; 0 means read
- data_sram_addr  in  32  data byte address
- data_sram_wdata  in  32  store data, byte-lane aligned
- data_sram_rdata  out  32  load word; held until the next completed data read
- stallreq_for_bus  out  1  pipeline stall request to CTRL
- arid/araddr/arvalid  out  4/32/1  read address; arready in 1
- arlen=0, arsize=2, arburst=01, arlock=0, arcache=0, arprot=0  out  constant fields on both AR and AW
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1
- awid/awaddr/awvalid  out  4/32/1; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
- bid/bresp/bvalid  in  4/2/1; bready out 1

## Operation
- FSM states: IDLE, AR, R, W (AW+W), B.
- Per-port done flags: inst_done, data_done.
- stallreq_for_bus = (inst_sram_en & ~inst_done) | (data_sram_en & ~data_done). It is forced to 0 while rst is high.
- Done flags clear on the edge where stallreq_for_bus is 0, because the pipeline advances on that edge.
- IDLE arbitration: a pending data request wins over a pending instruction request. Both ports pending means two serial transactions, and the stall is held until both are done.
- Read path: IDLE → AR.
  - AR: arvalid=1, arid = 0 for inst and 1 for data.
  - On arready, go to R. In R, rready=1.
  - On rvalid, latch rdata into the port's rdata register, set that port's done flag, return to IDLE.
  - rresp is ignored.
- Write path, taken when data_sram_wen≠0: IDLE → W.
  - awvalid and wvalid are raised together. Each one drops independently after its own handshake.
  - awaddr = data_sram_addr with bits[1:0] cleared. wstrb = wen. wlast=1. wdata = data_sram_wdata.
  - Go to B when both handshakes are complete. In B, bready=1; on bvalid set data_done and return to IDLE.
- IDs: awid=wid=1. Responses are matched by FSM state, not by id.
- Every address and data value driven on AXI is registered at request acceptance. AXI outputs never change while valid is high and ready is low.

## Timing
- Reset values:
  - All AXI valid outputs 0; rready=0, bready=0.
  - inst_sram_rdata=0, data_sram_rdata=0.
  - Done flags 0; FSM in IDLE.
- Zero-wait-slave read: request seen in cycle N (stall=1), arvalid in N+1, rvalid accepted in N+2, stall=0 in N+3. That is 3 stall cycles.
- Zero-wait-slave write: awvalid/wvalid in N+1, bvalid in N+2, stall=0 in N+3.
- Reset asserted mid-transaction: FSM returns to IDLE and all valids drop at the next edge. No response is awaited. The interconnect is reset by the same rst.
- The rdata registers change only on R-handshake edges.

## Configuration
- SRAM_AXI_POSTED_WRITE_EN defined:
  - data_done is set when both AW and W handshakes complete, and the FSM returns to IDLE without entering B.
  - A one-bit b_pending flag is set at that point; bready=1 while it is set; it clears on bvalid.
  - IDLE starts no new transaction while b_pending=1.
  - Zero-wait store stall drops to 2 cycles.
- Undefined: writes complete only through the B state, as described in Operation.

## Structure
- Package sram_axi_pkg holds:
  - FSM state enum
  - AXI constants: size 2, burst INCR=2'b01, ID_INST=4'd0, ID_DATA=4'd1
- Sub-module sram_axi_port_ctx, instantiated once per port, holds the done flag and the held rdata register. Inputs: en, grant-complete strobe, rdata, advance. Output: stall contribution.
- The top level holds the FSM and the AXI registers.

## Test plan
- Single fetch, addr 0xBFC00000, zero-wait slave returning 0x3C1D0000:
  - arid=0, araddr=0xBFC00000, arlen=0.
  - stall high for exactly 3 cycles, then inst_sram_rdata=0x3C1D0000.
- Simultaneous fetch at 0xBFC00004 and load at 0x80001000:
  - AR for the data access (arid=1) issued first, then AR for the instruction access (arid=0).
  - stall stays high until both are done, for 6 cycles with a zero-wait slave.
- sb store, wen=4'b0100, addr 0x80000002, wdata 0x00AB0000:
  - awaddr=0x80000000, wstrb=4'b0100, wlast=1.
  - awready delayed 2 cycles: awvalid and awaddr stable throughout.
- Backpressure, arready low for 5 cycles and rvalid delayed 4 cycles:
  - araddr held stable.
  - rdata latched only on the handshake edge; the previous rdata is held until then.
- rst pulsed while in R:
  - Next cycle: FSM in IDLE, all valids 0, rdata outputs 0, stall 0.
- With SRAM_AXI_POSTED_WRITE_EN, a store followed by a load, bvalid delayed 3 cycles:
  - Store stall is 2 cycles.
  - Load arvalid is not raised until the cycle after the bvalid handshake.
